// File: rtl/user_input_ctrl.sv
// user_input_ctrl: handshakes a processor IN instruction with a debounced confirm button and captures SW.
// Latency: capture 2 (sync) + DEB_MAX (debounce) cycles after a clean key_n fall, data_valid one cycle later.
// Backpressure: stall holds the processor while a request waits for a press; one capture per request.
// Ports: clk/reset (async, active-high); input_req level request; SW[14:0] switches and key_n
//        (async, key active-low); data_out {17'b0, SW}; data_valid one-cycle pulse; stall; waiting prompt.
module user_input_ctrl #(
  parameter int DEB_MAX = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        input_req,
  input  logic [14:0] SW,
  input  logic        key_n,
  output logic [31:0] data_out,
  output logic        data_valid,
  output logic        stall,
  output logic        waiting
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_RELEASE = 2'd1,
    WAIT_PRESS   = 2'd2,
    WAIT_DROP    = 2'd3
  } state_t;

  localparam logic [15:0] DEB_LAST = 16'(DEB_MAX - 1);

  logic [14:0] sw_meta, sw_s;
  logic        key_meta, key_s;
  logic [15:0] deb_cnt;
  logic        key_deb;
  logic        press_evt;
  logic        capture;
  state_t      state, state_nxt;

  // Two-flop synchronizers; key flops reset to the released level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_meta  <= '0;
      sw_s     <= '0;
      key_meta <= 1'b1;
      key_s    <= 1'b1;
    end else begin
      sw_meta  <= SW;
      sw_s     <= sw_meta;
      key_meta <= key_n;
      key_s    <= key_meta;
    end
  end

  // Debouncer: key_deb follows key_s only after DEB_MAX consecutive differing cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_cnt <= '0;
      key_deb <= 1'b1;
    end else if (key_s == key_deb) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      key_deb <= key_s;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + 16'd1;
    end
  end

  // High in the cycle whose clock edge moves key_deb from released to pressed.
  assign press_evt = key_deb && !key_s && (deb_cnt == DEB_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        // A button already held when the request arrives must be released first.
        if (input_req) state_nxt = key_deb ? WAIT_PRESS : WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (!input_req)   state_nxt = IDLE;
        else if (key_deb) state_nxt = WAIT_PRESS;
      end
      WAIT_PRESS: begin
        // A dropped request wins over a coincident press: nothing is captured.
        if (!input_req) begin
          state_nxt = IDLE;
        end else if (press_evt) begin
          capture   = 1'b1;
          state_nxt = WAIT_DROP;
        end
      end
      WAIT_DROP: begin
        if (!input_req) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= capture;
      if (capture) data_out <= {17'b0, sw_s};
    end
  end

  assign stall   = input_req && (state != WAIT_DROP);
  assign waiting = (state == WAIT_RELEASE) || (state == WAIT_PRESS);

endmodule

// File: doc/user_input_ctrl.md
USER_INPUT_CTRL -- requirements
Module: user_input_ctrl

Interface
REQ-001 Parameter DEB_MAX, default 50000, is the number of consecutive stable cycles required before a debounced key level changes (legal range 2..65535).
REQ-002 Port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-003 Port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-004 Port input_req, input, 1 bit: processor IN instruction pending, level, held high until data is accepted.
REQ-005 Port SW, input, 15 bits: slide-switch value, asynchronous to clk.
REQ-006 Port key_n, input, 1 bit: confirm pushbutton, active-low, asynchronous, bouncing.
REQ-007 Port data_out, output, 32 bits: captured user value, {17'b0, SW}.
REQ-008 Port data_valid, output, 1 bit: one-cycle pulse marking a new data_out.
REQ-009 Port stall, output, 1 bit: processor must hold while high.
REQ-010 Port waiting, output, 1 bit: high in WAIT_RELEASE or WAIT_PRESS; drives the display prompt.

Function
REQ-011 SW and key_n shall each pass through a 2-flop synchronizer; all logic shall use only the synchronized copies sw_s and key_s.
REQ-012 Debouncer: 16-bit counter deb_cnt, cleared whenever key_s == key_deb, incremented while key_s != key_deb.
REQ-013 When deb_cnt == DEB_MAX-1 and key_s != key_deb, the block shall set key_deb <= key_s and clear deb_cnt.
REQ-014 press_evt shall be high exactly in the cycle of the debouncer update that takes key_deb from 1 to 0.
REQ-015 The FSM states shall be IDLE, WAIT_RELEASE, WAIT_PRESS and WAIT_DROP.
REQ-016 IDLE: if input_req is high, go to WAIT_RELEASE when key_deb==0 (button already held), else go to WAIT_PRESS.
REQ-017 WAIT_RELEASE: if input_req is low go to IDLE; else if key_deb==1 go to WAIT_PRESS.
REQ-018 WAIT_PRESS: if input_req is low go to IDLE with no capture, and this takes priority over a simultaneous press_evt.
REQ-019 WAIT_PRESS, on press_evt: data_out <= {17'b0, sw_s}, data_valid <= 1 for one cycle, and go to WAIT_DROP.
REQ-020 WAIT_DROP: stay until input_req is low, then go to IDLE; further presses are ignored.
REQ-021 stall shall be combinational: input_req AND state in {IDLE, WAIT_RELEASE, WAIT_PRESS}; it is therefore low in the cycle data_valid is high.
REQ-022 data_out shall hold its last captured value until the next capture; press_evt outside WAIT_PRESS shall have no effect on data_out or data_valid.
REQ-023 Press-to-valid latency shall be at most 2 + DEB_MAX + 2 cycles after a clean key_n fall while in WAIT_PRESS.
REQ-024 Only one data_valid pulse shall occur per input_req assertion, regardless of press count.

Reset
REQ-025 While reset is high, and asynchronously on its assertion:
- state = IDLE;
- data_out = 0, data_valid = 0, waiting = 0;
- stall = input_req, as the combinational output in IDLE;
- deb_cnt = 0;
- key_deb = 1 and both key synchronizer flops = 1 (released);
- SW synchronizer flops = 0.
REQ-026 Reset asserted mid-operation shall abort any wait; no data_valid shall be generated for the aborted request.

Verification (DEB_MAX=4)
REQ-027 Reset check: assert reset with input_req=0 -> data_out=0, data_valid=0, stall=0, waiting=0, state IDLE.
REQ-028 Clean press:
- stimulus: input_req=1, SW=15'd12345, key_n low for 20 cycles;
- required: stall=1 and waiting=1 until delivery, then exactly one data_valid pulse within 8 cycles of the key_n fall;
- required: data_out=32'd12345 and stall=0 in the pulse cycle.
REQ-029 Bounce rejection: input_req=1, key_n toggling every 2 cycles for 12 cycles, then held high -> no data_valid, state stays WAIT_PRESS, stall=1.
REQ-030 Held button:
- stimulus: key_n held low 10 cycles before input_req rises;
- required: state WAIT_RELEASE and no data_valid while still held;
- required: after release and a new press, exactly one data_valid with the current SW.
REQ-031 Cancel and stray press:
- input_req dropped in WAIT_PRESS -> IDLE next cycle, no pulse, data_out unchanged;
- press with input_req=0 -> data_out unchanged, data_valid=0.
REQ-032 Reset mid-wait: reset pulsed in WAIT_PRESS with SW=15'd777 -> data_out=0, data_valid=0, state IDLE; re-request plus press -> data_out=32'd777.
